x_fetch: RTL

X_FETCH -- requirements
Module: x_fetch

---
 rtl/x_fetch_pkg.sv | 24 ++
 rtl/x_fetch_step_counter.sv | 50 +++++
 rtl/x_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/x_fetch_pkg.sv
// Shared LSTM definitions for the x-vector fetch path: FSM encoding,
// default geometry and the derived sequence length.
package x_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_NUM            = 45;
  localparam int DEF_NUM_ITERATIONS = 8;

  function automatic int seq_words(input int num, input int iters);
    return num * iters;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SEQ_WORDS = seq_words(DEF_NUM, DEF_NUM_ITERATIONS);

endpackage

// File: rtl/x_fetch_step_counter.sv
// Word-within-vector and timestep counters for one sequence fetch;
// the word counter wraps into the step counter.
module step_counter
  import x_fetch_pkg::*;
#(
  parameter int NUM            = DEF_NUM,
  parameter int NUM_ITERATIONS = DEF_NUM_ITERATIONS,
  localparam int WW            = cnt_width(NUM),
  localparam int SW            = cnt_width(NUM_ITERATIONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          clear,
  output logic [WW-1:0] word_cnt,
  output logic [SW-1:0] step_cnt,
  output logic          last_word,
  output logic          last_step
);

  localparam logic [WW-1:0] WORD_MAX = WW'(NUM - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(NUM_ITERATIONS - 1);

  logic [WW-1:0] r_word;
  logic [SW-1:0] r_step;

  // NOTE: clocked state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word <= '0;
      r_step <= '0;
    end else if (clear) begin
      r_word <= '0;
      r_step <= '0;
    end else if (advance) begin
      if (last_word) begin
        r_word <= '0;
        r_step <= last_step ? '0 : r_step + 1'b1;
      end else begin
        r_word <= r_word + 1'b1;
      end
    end
  end

  assign word_cnt  = r_word;
  assign step_cnt  = r_step;
  assign last_word = (r_word == WORD_MAX);
  assign last_step = (r_step == STEP_MAX);

endmodule

// File: rtl/x_fetch.sv
// Streams one stored input sequence (NUM words x NUM_ITERATIONS steps) from a
// combinational-read x memory to a valid/ready consumer, tagging vector/step ends.
module x_fetch
  import x_fetch_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUM            = DEF_NUM,
  parameter int NUM_ITERATIONS = DEF_NUM_ITERATIONS,
  parameter int NUM_SEQ        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic        [WIDTH-1:0] seq_sel,
  output logic        [WIDTH-1:0] addr,
  input  logic signed [WIDTH-1:0] mem_data,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last_word,
  output logic                    out_last_step,
  output logic                    busy,
  output logic                    done
);

  localparam int WW = cnt_width(NUM);
  localparam int SW = cnt_width(NUM_ITERATIONS);
  localparam logic [WIDTH-1:0] SEQ_LEN = WIDTH'(seq_words(NUM, NUM_ITERATIONS));

  state_t r_state;
  state_t w_next;

  logic        [WIDTH-1:0] r_addr;
  logic signed [WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_last_word;
  logic                    r_last_step;
  logic                    r_done;

  logic          w_accept;
  logic          w_load;
  logic          w_drain_exit;
  logic          w_busy;
  logic          w_last_word;
  logic          w_last_step;
  logic          w_final;
  logic [WW-1:0] w_word_cnt;
  logic [SW-1:0] w_step_cnt;
  logic          w_cnt_unused;

  step_counter #(
    .NUM            (NUM),
    .NUM_ITERATIONS (NUM_ITERATIONS)
  ) u_step_counter (
    .clk       (clk),
    .rst       (rst),
    .advance   (w_load),
    .clear     (w_accept),
    .word_cnt  (w_word_cnt),
    .step_cnt  (w_step_cnt),
    .last_word (w_last_word),
    .last_step (w_last_step)
  );

  // Raw counts and memory depth are not needed here; only the wrap flags are.
  assign w_cnt_unused = ^{w_word_cnt, w_step_cnt, NUM_SEQ[0]};
  assign w_final      = w_last_word && w_last_step;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)           w_next = FETCH;
      FETCH:   if (w_load && w_final)  w_next = DRAIN;
      DRAIN:   if (out_ready)          w_next = IDLE;
      default:                         w_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_busy       = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_drain_exit = 1'b0;
    case (r_state)
      // A start coinciding with the done pulse is dropped.
      IDLE:  w_accept = start && !r_done;
      FETCH: begin
        w_busy = 1'b1;
        w_load = !r_valid || out_ready;
      end
      DRAIN: begin
        w_busy       = 1'b1;
        w_drain_exit = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last_word <= 1'b0;
      r_last_step <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_drain_exit;
      // The final load leaves the address on the last word so it never leaves the sequence.
      if (w_accept)
        r_addr <= seq_sel * SEQ_LEN;
      else if (w_load && !w_final)
        r_addr <= r_addr + 1'b1;
      if (w_load) begin
        r_data      <= mem_data;
        r_valid     <= 1'b1;
        r_last_word <= w_last_word;
        r_last_step <= w_last_step;
      end else if (w_drain_exit) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign addr          = r_addr;
  assign out_data      = r_data;
  assign out_valid     = r_valid;
  assign out_last_word = r_last_word;
  assign out_last_step = r_last_step;
  assign busy          = w_busy;
  assign done          = r_done;

endmodule
